io_input_cond: RTL
==================

IO_INPUT_COND -- requirements
Module: io_input_cond

Interface
REQ-001 Parameter DB_CYCLES, default 500000, debounce hold time in io_clk cycles (10 ms at 50 MHz); legal range 1..1048575.
REQ-002 io_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 sw  input  10  raw DE2 slide switches, asynchronous to io_clk, 1 = up.
REQ-005 key  input  4  raw DE2 push-buttons, asynchronous, active-low (0 = pressed).
REQ-006 evt_clr  input  4  synchronous per-key event clear; bit i high for one or more cycles clears key_event[i].
REQ-007 in_port0  output  32  conditioned input word, driven directly from registers; feeds the I/O input register.
REQ-008 key_event  output  4  sticky press flags, also mirrored in in_port0.

Function
REQ-009 The block SHALL pass each of the 14 raw inputs through its own 2-flop synchronizer before any other use.
REQ-010 The block SHALL hold one stable register and one 20-bit counter per input.
REQ-011 When synchronized value equals stable value, the counter SHALL be 0 on the next cycle.
REQ-012 When they differ and counter < DB_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When they differ and counter = DB_CYCLES-1, the stable register SHALL take the synchronized value and the counter SHALL return to 0.
REQ-014 Latency: a raw change held steady is reflected in the stable register at rising edge DB_CYCLES+2, counting the first edge that samples it as edge 1.
REQ-015 A glitch shorter than DB_CYCLES synchronized cycles SHALL leave the stable register unchanged and restart the count from 0 on its return.
REQ-016 key_level[i] SHALL be the inverse of the stable key bit (1 = pressed).
REQ-017 key_event[i] SHALL set on the edge where key_level[i] goes 0->1; it SHALL stay set until cleared; a release SHALL NOT clear it.
REQ-018 evt_clr[i] SHALL clear key_event[i] on the next edge; if set and clear coincide on the same edge, set SHALL win.
REQ-019 Output map: in_port0[9:0] = stable sw; [13:10] = key_level; [17:14] = key_event; [31:18] = 0.
REQ-020 The counter SHALL never exceed DB_CYCLES-1; no wrap-around is possible.

Reset
REQ-021 On resetn low, all synchronizer flops and counters SHALL clear asynchronously to 0.
REQ-022 On resetn low, stable sw SHALL clear to 0, stable key SHALL set to 1 (released), and key_event SHALL clear to 0, so in_port0 = 0x00000000.
REQ-023 A reset asserted mid-debounce SHALL discard the partial count; no event SHALL be generated by reset or by its release.

Configuration
REQ-024 Macro IO_INPUT_COND_EVENT_EN defined: key_event logic and evt_clr SHALL operate as in REQ-017/018.
REQ-025 Macro IO_INPUT_COND_EVENT_EN undefined: no event registers SHALL be built, evt_clr SHALL be ignored, and key_event and in_port0[17:14] SHALL be constant 0.

Verification (DB_CYCLES=4, macro defined unless stated)
REQ-026 Reset release with sw=0x3FF, key=0xF held -> in_port0 = 0x000003FF first at edge 6 after release.
REQ-027 Drive key[2]=0 held -> at edge 6, in_port0[12]=1 and [16]=1; later key[2]=1 -> [12]=0 after 6 edges while [16] stays 1.
REQ-028 sw[0] pulse of 3 cycles -> in_port0[0] never changes; a 4-cycle pulse -> changes at edge 6.
REQ-029 key_event[1] set, evt_clr=4'b0010 for 1 cycle -> key_event=0 next edge; evt_clr coinciding with a new press edge -> key_event[1] stays 1.
REQ-030 resetn pulsed low during a 3-cycle-old count on sw[5] -> in_port0 = 0 immediately (asynchronously); after release, sw[5] held -> appears after a full DB_CYCLES+2 edges.
REQ-031 Macro undefined, key[0] pressed -> in_port0[10]=1, in_port0[17:14]=0, key_event=0.

Source files
------------

// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - synchronise and debounce DE2 switches/keys into the I/O input word
// Optional feature macro: IO_INPUT_COND_EVENT_EN (sticky key-press event flags).
// Key inputs are inverted ahead of their synchronisers, so every internal path runs in
// "1 = active" polarity. The stable key register therefore holds key_level. A cleared
// register means "released", which matches the stable-key-reset-to-1 behaviour at the pins.
// This arrangement also keeps a reset from pairing a cleared key synchroniser with a
// released stable value, which would otherwise start a spurious debounce count.

module io_input_cond #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  input  logic [3:0]  evt_clr,
  output logic [31:0] in_port0,
  output logic [3:0]  key_event
);

  localparam int          NIN     = 14;
  localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

  // Bits [9:0] are switches (1 = up); bits [13:10] are keys (1 = pressed).
  logic [NIN-1:0]       raw_lvl;
  logic [NIN-1:0]       sync1_q;
  logic [NIN-1:0]       sync2_q;
  logic [NIN-1:0]       stable_q;
  logic [NIN-1:0]       stable_d;
  logic [NIN-1:0][19:0] cnt_q;
  logic [NIN-1:0][19:0] cnt_d;

  assign raw_lvl = {~key, sw};

  // Two-flop synchroniser per raw input
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_lvl;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles and adopt the new value at DB_CYCLES
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NIN; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // Stable values and debounce counters
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef IO_INPUT_COND_EVENT_EN
  logic [3:0] event_q;
  logic [3:0] event_d;
  logic [3:0] press;

  // A press is set in the same cycle that the debounced level rises; a set wins over a clear
  always_comb begin
    press   = stable_d[13:10] & ~stable_q[13:10];
    event_d = press | (event_q & ~evt_clr);
  end

  // Sticky press flags
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      event_q <= '0;
    end else begin
      event_q <= event_d;
    end
  end

  assign key_event = event_q;
`else
  logic unused_evt_clr;

  assign unused_evt_clr = ^evt_clr;
  assign key_event      = 4'h0;
`endif

  assign in_port0 = {14'h0, key_event, stable_q};

endmodule
